uart_imem_loader_gen2: RTL and testbench
========================================

Name: uart_imem_loader_gen2

Overview:
- Parametrised loader that assembles the UART RX byte stream into DATA_W-bit instruction words and writes them sequentially into the core's instruction memory.
- Terminates on an end-marker word and flags completion through write_done, which releases the RISC-V core from reset.
- Beyond the first-generation loader it adds:
  - generic word width and memory depth;
  - selectable byte order;
  - inter-byte timeout resynchronisation;
  - BREAK abort;
  - overflow detection;
  - an in-field reload.
- Sits between the UART receiver and the instruction-memory write port inside the top-level wrapper.

Parameters:
- DATA_W, 32, instruction word width in bits; multiple of 8, range 8..64
- ADDR_W, 10, word-address width of instruction memory
- DEPTH, 1024, number of writable words; must be <= 2**ADDR_W
- END_MARKER, all ones (DATA_W bits), terminating word; never written to memory
- BIG_ENDIAN, 0, 0 = first byte lands in [7:0]; 1 = first byte lands in [DATA_W-1:DATA_W-8]
- TIMEOUT_CYC, 1000000, idle clocks allowed between bytes of one word before the partial word is discarded; 0 disables timeout

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous active-high reset
- rx_valid  in  1  single-cycle strobe, one per received byte
- rx_data  in  8  received byte, valid when rx_valid=1
- rx_break  in  1  UART BREAK detected (level or pulse)
- reload  in  1  single-cycle request to restart loading from address 0
- mem_we  out  1  instruction-memory write enable, one-cycle pulse
- mem_addr  out  ADDR_W  word address of write
- mem_wdata  out  DATA_W  word to write
- write_done  out  1  load complete; held high until reload or rst
- busy  out  1  high while at least one byte of a word is buffered
- word_count  out  ADDR_W+1  words written in the current load
- err_overflow  out  1  sticky: non-marker word arrived after DEPTH words were written
- err_timeout  out  1  sticky: a partial word was discarded by timeout or BREAK

Behaviour:
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, write_done=0, busy=0, word_count=0, err_*=0, byte index=0, state=COLLECT.
- States:
  - COLLECT: accepting bytes.
  - WRITE: one cycle, drives mem_we.
  - DONE: terminal, bytes ignored.
  - OVF: terminal, bytes ignored.
- COLLECT:
  - On rx_valid, the byte is placed in lane byte_idx, or lane (DATA_W/8-1-byte_idx) when BIG_ENDIAN=1, and byte_idx increments.
  - When the last byte of a word is accepted, the completed word is evaluated in the next cycle:
    - equal to END_MARKER -> DONE; write_done=1 from that cycle, no write.
    - otherwise, if word_count < DEPTH -> WRITE.
    - otherwise -> OVF; err_overflow=1, no write.
- WRITE:
  - mem_we=1 for exactly one cycle, with mem_addr=word_count[ADDR_W-1:0] and mem_wdata=the assembled word.
  - Next cycle: word_count+1, mem_addr advances, return to COLLECT.
  - Latency: last-byte strobe to mem_we = 2 clocks.
  - A byte arriving during WRITE is accepted into the next word; UART byte spacing is far above 2 clocks, so nothing is lost.
- Timeout:
  - An idle counter runs while busy=1 and clears on every rx_valid.
  - On reaching TIMEOUT_CYC, buffered bytes are discarded, byte_idx=0, err_timeout=1.
  - Address and word_count are unchanged.
- rx_break in COLLECT:
  - Same discard as timeout; err_timeout=1.
  - A simultaneous rx_valid byte is dropped.
- busy is high when byte_idx != 0.
- reload, in any state:
  - Next cycle: COLLECT, byte_idx=0, word_count=0, mem_addr=0, write_done=0, err_*=0.
  - reload has priority over rx_valid, rx_break and timeout in the same cycle; the byte is dropped.
- DONE and OVF: rx_valid and rx_break are ignored; outputs hold.
- rst mid-word or mid-WRITE: all state clears immediately; mem_we deasserts asynchronously.
- Memory contents are not cleared by reset or reload.

Test Plan:
- Defaults. Send bytes 13 01 01 FA, then 23 2E 81 04, then FF FF FF FF -> mem_we at addr 0 data FA010113 and at addr 1 data 04812E23; write_done=1 two clocks after the final FF; word_count=2.
- BIG_ENDIAN=1. Send 04 81 2E 23 -> mem_wdata=04812E23 at addr 0.
- TIMEOUT_CYC=100. Send 2 bytes, idle 150 clocks, then send 13 01 01 FA -> err_timeout=1; single write FA010113 at addr 0.
- DEPTH=2. Send 3 non-marker words -> 2 writes at addr 0 and 1; err_overflow=1 after word 3; mem_we never asserted for word 3; write_done=0.
- After DONE, pulse reload coincident with an rx_valid byte -> that byte is dropped; write_done=0; the next full word is written at addr 0.
- Assert rx_break after 3 bytes, then assert rst during a WRITE cycle -> byte_idx=0 and err_timeout=1 after the break; all outputs 0 the instant rst rises.

Source files
------------

// File: rtl/uart_imem_loader_gen2.sv
`default_nettype none
// ============================================================================
// Module   : uart_imem_loader_gen2
// Purpose  : Packs the UART RX byte stream into DATA_W-bit words and writes
//            them to consecutive instruction-memory addresses. The load ends
//            on END_MARKER, which raises write_done to release the core.
//            It also provides:
//              - selectable byte order;
//              - inter-byte timeout resync;
//              - BREAK abort;
//              - overflow detection;
//              - in-field reload.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            rx_valid_i/rx_data_i - one strobe per received byte
//            rx_break_i          - UART BREAK, discards a partial word
//            reload_i            - restart loading from address 0
//            mem_we_o/mem_addr_o/mem_wdata_o - instruction-memory write port
//            write_done_o        - load complete (held until reload/rst)
//            busy_o              - partial word buffered
//            word_count_o        - words written in the current load
//            err_overflow_o      - sticky: word arrived with memory full
//            err_timeout_o       - sticky: partial word discarded
// Revision : 1.0  initial release
// ============================================================================
module uart_imem_loader_gen2 #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 10,
  parameter int unsigned       DEPTH       = 1024,
  parameter logic [DATA_W-1:0] END_MARKER  = '1,
  parameter bit                BIG_ENDIAN  = 1'b0,
  parameter int unsigned       TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_break_i,
  input  logic              reload_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              write_done_o,
  output logic              busy_o,
  output logic [ADDR_W:0]   word_count_o,
  output logic              err_overflow_o,
  output logic              err_timeout_o
);

  localparam int unsigned      NBYTES   = DATA_W / 8;
  localparam int unsigned      IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned      TO_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [ADDR_W:0]  DEPTH_W  = (ADDR_W + 1)'(DEPTH);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_WRITE   = 2'd1,
    ST_DONE    = 2'd2,
    ST_OVF     = 2'd3
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   byte_idx_q;
  logic [DATA_W-1:0]  asm_q;       // partial word being assembled
  logic [DATA_W-1:0]  word_q;      // completed word awaiting evaluation
  logic               word_full_q;
  logic [TO_W-1:0]    idle_q;
  logic               mem_we_q;
  logic [DATA_W-1:0]  mem_wdata_q;
  logic [ADDR_W:0]    word_count_q;
  logic               done_q;
  logic               err_ovf_q;
  logic               err_to_q;

  logic [IDX_W-1:0]   lane;
  logic [DATA_W-1:0]  asm_d;
  logic               busy;
  logic               timeout_hit;

  always_comb begin
    busy        = (byte_idx_q != '0);
    lane        = BIG_ENDIAN ? (LAST_IDX - byte_idx_q) : byte_idx_q;
    asm_d       = asm_q;
    asm_d[{lane, 3'b000} +: 8] = rx_data_i;
    // idle_q counts completed idle cycles, so the match on TIMEOUT_CYC-1
    // fires on the TIMEOUT_CYC-th idle clock.
    timeout_hit = (TIMEOUT_CYC != 0) && busy && !rx_valid_i && (idle_q == TO_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_COLLECT;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      word_q       <= '0;
      word_full_q  <= 1'b0;
      idle_q       <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      word_count_q <= '0;
      done_q       <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_to_q     <= 1'b0;
    end else if (reload_i) begin
      // Reload outranks every other event this cycle; a coincident byte is lost.
      state_q      <= ST_COLLECT;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      word_full_q  <= 1'b0;
      idle_q       <= '0;
      mem_we_q     <= 1'b0;
      word_count_q <= '0;
      done_q       <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_to_q     <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;

      // Word evaluation / write sequencing.
      case (state_q)
        ST_COLLECT: begin
          if (word_full_q) begin
            word_full_q <= 1'b0;
            if (word_q == END_MARKER) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else if (word_count_q < DEPTH_W) begin
              state_q     <= ST_WRITE;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= word_q;
            end else begin
              state_q   <= ST_OVF;
              err_ovf_q <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          state_q      <= ST_COLLECT;
          word_count_q <= word_count_q + 1'b1;
        end
        default: ;
      endcase

      // Byte intake keeps running during WRITE so the next word can start;
      // it is placed after the evaluation so a newly completed word wins.
      if (state_q == ST_COLLECT || state_q == ST_WRITE) begin
        if (rx_break_i) begin
          byte_idx_q <= '0;
          asm_q      <= '0;
          idle_q     <= '0;
          err_to_q   <= 1'b1;
        end else if (rx_valid_i) begin
          idle_q <= '0;
          if (byte_idx_q == LAST_IDX) begin
            word_q      <= asm_d;
            word_full_q <= 1'b1;
            byte_idx_q  <= '0;
            asm_q       <= '0;
          end else begin
            asm_q      <= asm_d;
            byte_idx_q <= byte_idx_q + 1'b1;
          end
        end else if (timeout_hit) begin
          byte_idx_q <= '0;
          asm_q      <= '0;
          idle_q     <= '0;
          err_to_q   <= 1'b1;
        end else if (busy) begin
          idle_q <= idle_q + 1'b1;
        end
      end
    end
  end

  // The write address is the count of words already written.
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = word_count_q[ADDR_W-1:0];
  assign mem_wdata_o    = mem_wdata_q;
  assign write_done_o   = done_q;
  assign busy_o         = busy;
  assign word_count_o   = word_count_q;
  assign err_overflow_o = err_ovf_q;
  assign err_timeout_o  = err_to_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_imem_loader_gen2.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_imem_loader_gen2
// Purpose  : Directed self-checking bench for uart_imem_loader_gen2.
//            Instance A: little-endian, DEPTH=2, TIMEOUT_CYC=100.
//            Instance B: big-endian, default depth and timeout.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_imem_loader_gen2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  // Instance A signals
  logic        a_rx_valid = 1'b0, a_rx_break = 1'b0, a_reload = 1'b0;
  logic [7:0]  a_rx_data = 8'h00;
  logic        a_mem_we, a_done, a_busy, a_err_ovf, a_err_to;
  logic [9:0]  a_mem_addr;
  logic [31:0] a_mem_wdata;
  logic [10:0] a_count;

  // Instance B signals
  logic        b_rx_valid = 1'b0, b_rx_break = 1'b0, b_reload = 1'b0;
  logic [7:0]  b_rx_data = 8'h00;
  logic        b_mem_we, b_done, b_busy, b_err_ovf, b_err_to;
  logic [9:0]  b_mem_addr;
  logic [31:0] b_mem_wdata;
  logic [10:0] b_count;

  uart_imem_loader_gen2 #(
    .DATA_W(32), .ADDR_W(10), .DEPTH(2), .END_MARKER(32'hFFFF_FFFF),
    .BIG_ENDIAN(1'b0), .TIMEOUT_CYC(100)
  ) u_dut_a (
    .clk(clk), .rst(rst),
    .rx_valid_i(a_rx_valid), .rx_data_i(a_rx_data),
    .rx_break_i(a_rx_break), .reload_i(a_reload),
    .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata),
    .write_done_o(a_done), .busy_o(a_busy), .word_count_o(a_count),
    .err_overflow_o(a_err_ovf), .err_timeout_o(a_err_to)
  );

  uart_imem_loader_gen2 #(
    .DATA_W(32), .ADDR_W(10), .DEPTH(1024), .END_MARKER(32'hFFFF_FFFF),
    .BIG_ENDIAN(1'b1), .TIMEOUT_CYC(1000000)
  ) u_dut_b (
    .clk(clk), .rst(rst),
    .rx_valid_i(b_rx_valid), .rx_data_i(b_rx_data),
    .rx_break_i(b_rx_break), .reload_i(b_reload),
    .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata),
    .write_done_o(b_done), .busy_o(b_busy), .word_count_o(b_count),
    .err_overflow_o(b_err_ovf), .err_timeout_o(b_err_to)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Write logs, sampled on the falling edge.
  logic [31:0] la_data [8];
  logic [9:0]  la_addr [8];
  int          la_n = 0;
  logic [31:0] lb_data [8];
  logic [9:0]  lb_addr [8];
  int          lb_n = 0;

  always @(negedge clk) begin
    if (a_mem_we === 1'b1 && la_n < 8) begin
      la_data[la_n] = a_mem_wdata;
      la_addr[la_n] = a_mem_addr;
      la_n = la_n + 1;
    end
    if (b_mem_we === 1'b1 && lb_n < 8) begin
      lb_data[lb_n] = b_mem_wdata;
      lb_addr[lb_n] = b_mem_addr;
      lb_n = lb_n + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle strobe; returns on the falling edge right after it.
  task automatic drive_byte(input bit sel_b, input logic [7:0] b);
    @(negedge clk);
    if (sel_b) begin b_rx_data = b; b_rx_valid = 1'b1; end
    else       begin a_rx_data = b; a_rx_valid = 1'b1; end
    @(negedge clk);
    a_rx_valid = 1'b0;
    b_rx_valid = 1'b0;
  endtask

  task automatic send_byte(input bit sel_b, input logic [7:0] b);
    drive_byte(sel_b, b);
    repeat (3) @(negedge clk);
  endtask

  task automatic send_word_a(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(1'b0, w[8*i +: 8]);
  endtask

  task automatic pulse_reload_a;
    @(negedge clk);
    a_reload = 1'b1;
    @(negedge clk);
    a_reload = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ---- reset state ----
    check_eq("rst_we",    a_mem_we,    0);
    check_eq("rst_addr",  a_mem_addr,  0);
    check_eq("rst_wdata", a_mem_wdata, 0);
    check_eq("rst_done",  a_done,      0);
    check_eq("rst_busy",  a_busy,      0);
    check_eq("rst_count", a_count,     0);
    check_eq("rst_errs",  {a_err_ovf, a_err_to}, 0);

    // ---- default load: two words then end marker ----
    la_n = 0;
    send_byte(1'b0, 8'h13);
    check_eq("busy_1byte", a_busy, 1);
    send_byte(1'b0, 8'h01);
    send_byte(1'b0, 8'h01);
    send_byte(1'b0, 8'hFA);
    send_byte(1'b0, 8'h23);
    send_byte(1'b0, 8'h2E);
    send_byte(1'b0, 8'h81);
    drive_byte(1'b0, 8'h04);
    check_eq("lat_we_1clk", a_mem_we, 0);
    @(negedge clk);
    check_eq("lat_we_2clk", a_mem_we,    1);
    check_eq("w1_addr",     a_mem_addr,  1);
    check_eq("w1_data",     a_mem_wdata, 32'h0481_2E23);
    @(negedge clk);
    check_eq("we_one_cyc",  a_mem_we, 0);
    check_eq("cnt_after2",  a_count,  2);
    check_eq("log_n_2",     la_n,     2);
    check_eq("log0_addr",   la_addr[0], 0);
    check_eq("log0_data",   la_data[0], 32'hFA01_0113);
    repeat (2) @(negedge clk);
    send_byte(1'b0, 8'hFF);
    send_byte(1'b0, 8'hFF);
    send_byte(1'b0, 8'hFF);
    drive_byte(1'b0, 8'hFF);
    check_eq("done_1clk", a_done, 0);
    @(negedge clk);
    check_eq("done_2clk", a_done,   1);
    check_eq("done_cnt",  a_count,  2);
    check_eq("marker_nowr", la_n,   2);
    send_byte(1'b0, 8'h55);
    check_eq("done_ignore_busy", a_busy, 0);

    // ---- reload coincident with a byte ----
    @(negedge clk);
    a_reload = 1'b1; a_rx_valid = 1'b1; a_rx_data = 8'hAA;
    @(negedge clk);
    a_reload = 1'b0; a_rx_valid = 1'b0;
    check_eq("rl_done",  a_done,  0);
    check_eq("rl_count", a_count, 0);
    check_eq("rl_busy",  a_busy,  0);
    la_n = 0;
    send_word_a(32'h4433_2211);
    repeat (2) @(negedge clk);
    check_eq("rl_wr_n",    la_n,       1);
    check_eq("rl_wr_addr", la_addr[0], 0);
    check_eq("rl_wr_data", la_data[0], 32'h4433_2211);

    // ---- timeout resync ----
    pulse_reload_a();
    la_n = 0;
    send_byte(1'b0, 8'hDE);
    send_byte(1'b0, 8'hAD);
    repeat (90) @(negedge clk);
    check_eq("to_not_yet", a_busy, 1);
    check_eq("to_err_0",   a_err_to, 0);
    repeat (60) @(negedge clk);
    check_eq("to_busy", a_busy,   0);
    check_eq("to_err",  a_err_to, 1);
    check_eq("to_cnt",  a_count,  0);
    send_word_a(32'hFA01_0113);
    repeat (2) @(negedge clk);
    check_eq("to_wr_n",    la_n,       1);
    check_eq("to_wr_addr", la_addr[0], 0);
    check_eq("to_wr_data", la_data[0], 32'hFA01_0113);

    // ---- overflow with DEPTH=2 ----
    pulse_reload_a();
    la_n = 0;
    send_word_a(32'h0102_0304);
    send_word_a(32'h0506_0708);
    send_word_a(32'h090A_0B0C);
    repeat (2) @(negedge clk);
    check_eq("ovf_n",     la_n,       2);
    check_eq("ovf_addr1", la_addr[1], 1);
    check_eq("ovf_data1", la_data[1], 32'h0506_0708);
    check_eq("ovf_err",   a_err_ovf,  1);
    check_eq("ovf_done",  a_done,     0);
    check_eq("ovf_cnt",   a_count,    2);

    // ---- big-endian instance ----
    lb_n = 0;
    send_byte(1'b1, 8'h04);
    send_byte(1'b1, 8'h81);
    send_byte(1'b1, 8'h2E);
    send_byte(1'b1, 8'h23);
    repeat (2) @(negedge clk);
    check_eq("be_n",    lb_n,       1);
    check_eq("be_addr", lb_addr[0], 0);
    check_eq("be_data", lb_data[0], 32'h0481_2E23);

    // ---- BREAK abort then rst during WRITE ----
    pulse_reload_a();
    send_byte(1'b0, 8'h11);
    send_byte(1'b0, 8'h22);
    send_byte(1'b0, 8'h33);
    check_eq("brk_pre_busy", a_busy, 1);
    @(negedge clk);
    a_rx_break = 1'b1;
    @(negedge clk);
    a_rx_break = 1'b0;
    check_eq("brk_busy", a_busy,   0);
    check_eq("brk_err",  a_err_to, 1);
    send_byte(1'b0, 8'hA1);
    send_byte(1'b0, 8'hB2);
    send_byte(1'b0, 8'hC3);
    drive_byte(1'b0, 8'hD4);
    @(negedge clk);
    check_eq("brk_wr_we",   a_mem_we,    1);
    check_eq("brk_wr_data", a_mem_wdata, 32'hD4C3_B2A1);
    #1 rst = 1'b1;
    #1;
    check_eq("arst_we",    a_mem_we,    0);
    check_eq("arst_wdata", a_mem_wdata, 0);
    check_eq("arst_flags", {a_done, a_busy, a_err_ovf, a_err_to}, 0);
    check_eq("arst_cnt",   a_count,     0);
    check_eq("arst_addr",  a_mem_addr,  0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
